// File: rtl/pool_engine_v2.sv
// Max-pooling engine: LANES FP16 channels over k x k windows, -inf padding, serial per-lane writeback.
// Per pixel: k*k + RD_LAT + 1 cycles to the first output_en; each word is held until output_ready.
module pool_engine_v2 #(
  parameter  int LANES  = 8,
  parameter  int DW     = 16,
  parameter  int ADDR_W = 12,
  parameter  int SIDE_W = 8,
  parameter  int RD_LAT = 1,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  engine_valid,
  input  logic [SIDE_W-1:0]     kernel,
  input  logic [SIDE_W-1:0]     stride,
  input  logic [SIDE_W-1:0]     pad,
  input  logic [SIDE_W-1:0]     i_side,
  input  logic [SIDE_W-1:0]     o_side,
  input  logic                  relu_en,
  input  logic [ADDR_W-1:0]     d_base,
  output logic                  d_ram_read_en,
  output logic [ADDR_W-1:0]     d_ram_read_addr,
  input  logic [LANES*DW-1:0]   input_data,
  output logic                  output_en,
  input  logic                  output_ready,
  output logic [DW-1:0]         output_data,
  output logic [LW-1:0]         out_lane,
  output logic                  pool_finish,
  output logic                  busy,
  output logic [31:0]           timer
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam int                IW        = 2 * SIDE_W + 2;
  localparam logic [SIDE_W-1:0] S_ONE     = SIDE_W'(1);
  localparam logic [DW-1:0]     NEG_INF   = DW'(16'hFC00);
  localparam logic [LW-1:0]     LAST_LANE = LW'(LANES - 1);

  state_t              r_state, w_next;
  logic [SIDE_W-1:0]   r_k, r_s, r_p, r_is, r_os;
  logic [SIDE_W-1:0]   r_kx, r_ky, r_ox, r_oy;
  logic                r_relu;
  logic [ADDR_W-1:0]   r_base;
  logic [LW-1:0]       r_lane;
  logic [RD_LAT-1:0]   r_vpipe, r_opipe, r_fpipe;
  logic [DW-1:0]       r_acc [LANES];
  logic [DW-1:0]       r_wb  [LANES];
  logic [DW-1:0]       w_tap [LANES];
  logic [31:0]         r_timer;
  logic [SIDE_W-1:0]   w_km1, w_osm1;
  logic [IW-1:0]       w_iy, w_ix, w_lin;
  logic                w_inb, w_last_tap, w_last_pix, w_degen;

  // Order-preserving unsigned key for FP16: larger key means larger value, -0 < +0.
  function automatic logic [DW-1:0] f_key(input logic [DW-1:0] x);
    return x[DW-1] ? ~x : {1'b1, x[DW-2:0]};
  endfunction

  assign w_km1      = r_k - S_ONE;
  assign w_osm1     = r_os - S_ONE;
  assign w_iy       = IW'(r_oy) * IW'(r_s) + IW'(r_ky) - IW'(r_p);
  assign w_ix       = IW'(r_ox) * IW'(r_s) + IW'(r_kx) - IW'(r_p);
  assign w_inb      = !w_iy[IW-1] && !w_ix[IW-1] && (w_iy < IW'(r_is)) && (w_ix < IW'(r_is));
  assign w_lin      = w_iy * IW'(r_is) + w_ix;
  assign w_last_tap = (r_kx == w_km1) && (r_ky == w_km1);
  assign w_last_pix = (r_ox == w_osm1) && (r_oy == w_osm1);
  assign w_degen    = (kernel == '0) || (stride == '0) || (o_side == '0);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_tap[l] = r_opipe[RD_LAT-1] ? NEG_INF : input_data[l*DW +: DW];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (engine_valid) w_next = w_degen ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last_tap) w_next = S_DRAIN;
      S_DRAIN: if (r_vpipe == '0) w_next = S_WRITE;
      S_WRITE: if (output_ready && (r_lane == LAST_LANE)) w_next = w_last_pix ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_s     <= '0;
      r_p     <= '0;
      r_is    <= '0;
      r_os    <= '0;
      r_kx    <= '0;
      r_ky    <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_relu  <= 1'b0;
      r_base  <= '0;
      r_lane  <= '0;
      r_vpipe <= '0;
      r_opipe <= '0;
      r_fpipe <= '0;
      r_timer <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_acc[l] <= '0;
        r_wb[l]  <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (engine_valid) begin
            r_k    <= kernel;
            r_s    <= stride;
            r_p    <= pad;
            r_is   <= i_side;
            r_os   <= o_side;
            r_relu <= relu_en;
            r_base <= d_base;
            r_kx   <= '0;
            r_ky   <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_lane <= '0;
          end
        end
        S_ISSUE: begin
          if (r_kx == w_km1) begin
            r_kx <= '0;
            r_ky <= (r_ky == w_km1) ? '0 : r_ky + S_ONE;
          end else begin
            r_kx <= r_kx + S_ONE;
          end
        end
        S_DRAIN: begin
          if (r_vpipe == '0) begin
            for (int l = 0; l < LANES; l++) begin
              r_wb[l] <= (r_relu && r_acc[l][DW-1]) ? '0 : r_acc[l];
            end
          end
        end
        S_WRITE: begin
          if (output_ready) begin
            if (r_lane == LAST_LANE) begin
              r_lane <= '0;
              if (r_ox == w_osm1) begin
                r_ox <= '0;
                r_oy <= r_oy + S_ONE;
              end else begin
                r_ox <= r_ox + S_ONE;
              end
            end else begin
              r_lane <= r_lane + LW'(1);
            end
          end
        end
        default: ;
      endcase

      // Padded taps travel the same pipe as real reads and are replaced by -inf on exit.
      r_vpipe[0] <= (r_state == S_ISSUE);
      r_opipe[0] <= !w_inb;
      r_fpipe[0] <= (r_kx == '0) && (r_ky == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_opipe[i] <= r_opipe[i-1];
        r_fpipe[i] <= r_fpipe[i-1];
      end

      if (r_vpipe[RD_LAT-1]) begin
        for (int l = 0; l < LANES; l++) begin
          if (r_fpipe[RD_LAT-1] || (f_key(w_tap[l]) > f_key(r_acc[l]))) r_acc[l] <= w_tap[l];
        end
      end

      if ((r_state != S_IDLE) && (r_timer != '1)) r_timer <= r_timer + 32'd1;
    end
  end

  assign busy            = (r_state != S_IDLE);
  assign pool_finish     = (r_state == S_DONE);
  assign d_ram_read_en   = (r_state == S_ISSUE) && w_inb;
  assign d_ram_read_addr = d_ram_read_en ? r_base + ADDR_W'(w_lin) : '0;
  assign output_en       = (r_state == S_WRITE);
  assign output_data     = r_wb[r_lane];
  assign out_lane        = r_lane;
  assign timer           = r_timer;

endmodule
